lms_coef_update: RTL and testbench

Adaptive coefficient generator for the 16-tap equalizer FIR. It tracks the same input sample stream as the filter and accepts an error sample per adaptation step. It computes sign-correct LMS updates c[k] += mu*e*x[n-k] serially, one tap per cycle, and drives the filter's coefficient bus. Coefficients change atomically, and a host load path allows direct coefficient writes.

---
 rtl/lms_pkg.sv | 35 +++
 rtl/lms_coef_update_tap.sv | 42 ++++
 rtl/lms_coef_update.sv | 138 +++++++++++++
 tb/tb_lms_coef_update.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared constants, types and the saturation helper for the LMS coefficient
// generator and the equalizer FIR it feeds.
package lms_pkg;

  localparam int unsigned NTAPS = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 14;
  localparam int unsigned AW    = $clog2(NTAPS);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    COMMIT
  } state_t;

  typedef logic signed [DW-1:0] samp_t;

  // Coefficient bus as seen by the filter: tap k lives in coef[k].
  typedef logic [NTAPS-1:0][DW-1:0] coef_bus_t;

  // Clamp to the DW-bit signed range. The input carries two guard bits so
  // that a DW-bit coefficient plus a (DW+1)-bit delta cannot wrap.
  function automatic samp_t sat_dw(input logic signed [DW+1:0] v);
    samp_t r;
    if (!v[DW+1] && (v[DW:DW-1] != 2'b00)) begin
      r = {1'b0, {(DW-1){1'b1}}};
    end else if (v[DW+1] && (v[DW:DW-1] != 2'b11)) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lms_coef_update_tap.sv
// Single-tap LMS step: c_new = sat(c_old + round(x*e / 2^(FRAC+mu_shift))).
// Purely combinational; the top feeds it one tap per cycle.
module lms_tap_update
  import lms_pkg::*;
(
  input  samp_t       x,
  input  samp_t       e,
  input  logic [3:0]  mu_shift,
  input  samp_t       c_old,
  output samp_t       c_new
);

  logic [4:0]             s;
  logic signed [2*DW-1:0] prod;
  logic signed [2*DW:0]   half;
  logic signed [2*DW:0]   rsum;
  logic signed [2*DW:0]   shifted;
  logic signed [DW:0]     delta;
  logic signed [DW+1:0]   sum;

  always_comb begin
    s       = 5'(FRAC) + {1'b0, mu_shift};
    prod    = (2*DW)'(x) * (2*DW)'(e);
    half    = '0;
    half[s - 5'd1] = 1'b1;
    rsum    = {prod[2*DW-1], prod} + half;
    shifted = rsum >>> s;

    // Only (-2^15)^2 can push delta past DW+1 bits; clamp so the sum stays exact.
    if ((shifted[2*DW:DW] == '0) || (shifted[2*DW:DW] == '1)) begin
      delta = shifted[DW:0];
    end else if (shifted[2*DW]) begin
      delta = {1'b1, {DW{1'b0}}};
    end else begin
      delta = {1'b0, {DW{1'b1}}};
    end

    sum   = {c_old[DW-1], c_old[DW-1], c_old} + {delta[DW], delta};
    c_new = sat_dw(sum);
  end

endmodule

// File: rtl/lms_coef_update.sv
// Serial LMS coefficient generator: snapshots the sample history on error
// accept, updates a shadow bank one tap per cycle, then commits atomically.
module lms_coef_update
  import lms_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_valid,
  input  logic signed [DW-1:0] xn,
  input  logic               adapt_en,
  input  logic               e_valid,
  output logic               e_ready,
  input  logic signed [DW-1:0] en,
  input  logic [3:0]         mu_shift,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [AW-1:0]      ld_addr,
  input  logic signed [DW-1:0] ld_data,
  input  logic               ld_last,
  output coef_bus_t          coef,
  output logic               coef_update,
  output logic               busy
);

  state_t        state, state_nxt;
  samp_t         hist   [NTAPS];
  samp_t         work   [NTAPS];
  samp_t         shadow [NTAPS];
  samp_t         e_lat;
  logic [3:0]    mu_lat;
  logic [AW-1:0] idx;
  logic          ld_acc;
  logic          e_acc;
  samp_t         c_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ld_acc && ld_last) begin
          state_nxt = COMMIT;
        end else if (e_acc) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        if (idx == AW'(NTAPS-1)) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load wins a same-cycle conflict by masking e_ready.
  always_comb begin
    ld_ready = (state == IDLE);
    e_ready  = (state == IDLE) && adapt_en && !ld_valid;
    busy     = (state != IDLE);
    ld_acc   = ld_valid && ld_ready;
    e_acc    = e_valid && e_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        hist[k] <= '0;
      end
    end else if (x_valid) begin
      hist[0] <= xn;
      for (int unsigned k = 1; k < NTAPS; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        work[k] <= '0;
      end
      e_lat  <= '0;
      mu_lat <= '0;
      idx    <= '0;
    end else if (e_acc) begin
      work   <= hist;
      e_lat  <= en;
      mu_lat <= mu_shift;
      idx    <= '0;
    end else if (state == UPDATE) begin
      idx <= idx + AW'(1);
    end
  end

  lms_tap_update u_tap (
    .x        (work[idx]),
    .e        (e_lat),
    .mu_shift (mu_lat),
    .c_old    (shadow[idx]),
    .c_new    (c_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
      end
    end else if (state == UPDATE) begin
      shadow[idx] <= c_new;
    end else if (ld_acc) begin
      shadow[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef        <= '0;
      coef_update <= 1'b0;
    end else begin
      coef_update <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
          coef[k] <= shadow[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_lms_coef_update.sv
// Directed-vector bench for lms_coef_update with hand-computed expectations.
module tb_lms_coef_update;
  import lms_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              x_valid;
  logic signed [15:0] xn;
  logic              adapt_en;
  logic              e_valid;
  logic              e_ready;
  logic signed [15:0] en;
  logic [3:0]        mu_shift;
  logic              ld_valid;
  logic              ld_ready;
  logic [3:0]        ld_addr;
  logic signed [15:0] ld_data;
  logic              ld_last;
  coef_bus_t         coef;
  logic              coef_update;
  logic              busy;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int pulse_cnt = 0;
  int exp_c [NTAPS];
  int p0;
  int cyc;

  always #5 clk = ~clk;

  lms_coef_update dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_valid     (x_valid),
    .xn          (xn),
    .adapt_en    (adapt_en),
    .e_valid     (e_valid),
    .e_ready     (e_ready),
    .en          (en),
    .mu_shift    (mu_shift),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .coef        (coef),
    .coef_update (coef_update),
    .busy        (busy)
  );

  always @(negedge clk) if (coef_update === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp;
    for (int k = 0; k < NTAPS; k++) exp_c[k] = 0;
  endtask

  task automatic check_coefs(input string tag);
    for (int k = 0; k < NTAPS; k++)
      chk($sformatf("%s[%0d]", tag, k), $signed(coef[k]), exp_c[k]);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ld_valid = 1'b0; e_valid = 1'b0; x_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic push_x(input int v);
    xn = 16'(v); x_valid = 1'b1;
    tick;
    x_valid = 1'b0;
  endtask

  task automatic load(input int addr, input int data, input logic last);
    ld_addr = 4'(addr); ld_data = 16'(data); ld_last = last; ld_valid = 1'b1;
    for (int i = 0; i < 50 && !ld_ready; i++) tick;
    if (!ld_ready) chk("ld_ready_timeout", 0, 1);
    tick;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic adapt(input int e, input int mu, input bit wiggle_x, output int cycles);
    en = 16'(e); mu_shift = 4'(mu); e_valid = 1'b1;
    for (int i = 0; i < 50 && !e_ready; i++) tick;
    if (!e_ready) chk("e_ready_timeout", 0, 1);
    tick;
    e_valid = 1'b0; en = 16'sh7fff; mu_shift = 4'd15;
    cycles = 0;
    while (busy && cycles < 40) begin
      if (wiggle_x) begin
        x_valid = 1'b1; xn = 16'($urandom);
      end
      tick;
      cycles++;
    end
    x_valid = 1'b0;
    if (cycles >= 40) chk("busy_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; x_valid = 1'b0; xn = '0; adapt_en = 1'b1; e_valid = 1'b0;
    en = '0; mu_shift = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;

    clear_exp;
    check_coefs("rst_coef");
    chk("rst_coef_update", coef_update, 0);
    chk("rst_busy", busy, 0);
    chk("rst_e_ready", e_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);

    p0 = pulse_cnt;
    load(3, 4096, 1'b0);
    chk("ld_no_commit", $signed(coef[3]), 0);
    load(7, -4096, 1'b1);
    chk("ld_pre_commit", $signed(coef[7]), 0);
    chk("ld_busy_commit", busy, 1);
    tick;
    chk("ld_pulse", coef_update, 1);
    exp_c[3] = 4096; exp_c[7] = -4096;
    check_coefs("ld_coef");
    tick;
    chk("ld_pulse_count", pulse_cnt - p0, 1);

    do_reset;
    clear_exp;
    push_x(16384);
    p0 = pulse_cnt;
    adapt(16384, 0, 1'b0, cyc);
    chk("upd_busy_cycles", cyc, 17);
    chk("upd_pulse", coef_update, 1);
    exp_c[0] = 16384;
    check_coefs("upd_coef");
    adapt(16384, 2, 1'b0, cyc);
    chk("upd_mu2", $signed(coef[0]), 20480);
    tick;
    chk("upd_pulse_count", pulse_cnt - p0, 2);

    do_reset;
    push_x(1);
    adapt(8192, 0, 1'b0, cyc);
    chk("rnd_half_up", $signed(coef[0]), 1);
    adapt(8191, 0, 1'b0, cyc);
    chk("rnd_below_half", $signed(coef[0]), 1);
    push_x(-1);
    adapt(8192, 0, 1'b0, cyc);
    chk("rnd_neg_half", $signed(coef[0]), 1);
    chk("rnd_tap1", $signed(coef[1]), 1);

    do_reset;
    load(0, 32000, 1'b1);
    tick;
    chk("sat_preload", $signed(coef[0]), 32000);
    push_x(16384);
    adapt(16384, 0, 1'b0, cyc);
    chk("sat_pos", $signed(coef[0]), 32767);
    load(0, -32000, 1'b1);
    tick;
    adapt(-16384, 0, 1'b0, cyc);
    chk("sat_neg", $signed(coef[0]), -32768);

    do_reset;
    clear_exp;
    push_x(100); push_x(-200); push_x(300);
    adapt(16384, 1, 1'b1, cyc);
    exp_c[0] = 150; exp_c[1] = -100; exp_c[2] = 50;
    check_coefs("snap");

    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'sd777; ld_last = 1'b0;
    e_valid = 1'b1; en = 16'sd16384; mu_shift = 4'd0;
    #1;
    chk("conf_e_ready", e_ready, 0);
    chk("conf_ld_ready", ld_ready, 1);
    tick;
    ld_valid = 1'b0; e_valid = 1'b0;
    chk("conf_not_busy", busy, 0);
    load(6, 0, 1'b1);
    tick;
    chk("conf_load_landed", $signed(coef[5]), 777);

    do_reset;
    clear_exp;
    push_x(16384);
    en = 16'sd16384; mu_shift = 4'd0; e_valid = 1'b1;
    tick;
    e_valid = 1'b0;
    chk("mid_busy", busy, 1);
    repeat (7) tick;
    p0 = pulse_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    check_coefs("mid_rst_coef");
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (20) tick;
    chk("mid_rst_no_pulse", pulse_cnt - p0, 0);
    chk("mid_rst_coef0", $signed(coef[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
